sinc3_post_conditioner: RTL and testbench



---
 rtl/sinc3_post_conditioner.sv | 130 +++++++++++++
 tb/tb_sinc3_post_conditioner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sinc3_post_conditioner.sv
// Offset/gain conditioner for sinc3 output: 3-edge pipeline from din_en into a show-ahead FIFO.
// Consumer backpressure via m_ready; samples arriving while the FIFO is full are dropped and counted.
module sinc3_post_conditioner #(
    parameter int DEPTH     = 8,
    parameter int GAIN_FRAC = 14,
    parameter int LW        = $clog2(DEPTH) + 1
) (
    input  logic          mclk1,
    input  logic          reset,
    input  logic [15:0]   din,
    input  logic          din_en,
    input  logic [15:0]   offset,
    input  logic [15:0]   gain,
    output logic [15:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [LW-1:0] fifo_level,
    output logic          sat,
    output logic [7:0]    overflow_cnt,
    input  logic          clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic signed [34:0] HALF = 35'sd1 <<< (GAIN_FRAC - 1);
    localparam logic signed [34:0] SMAX = 35'sd32767;
    localparam logic signed [34:0] SMIN = -35'sd32768;

    logic                 en_q;
    logic                 s1_vld;
    logic                 s2_vld;
    logic signed [16:0]   s1_diff;
    logic [15:0]          s1_gain;
    logic signed [33:0]   s2_prod;

    logic signed [34:0]   rnd;
    logic signed [34:0]   shifted;
    logic [15:0]          res;
    logic                 clip;

    logic [15:0]          mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic                 full;
    logic                 pop;
    logic                 wr_en;
    logic                 drop;

    // din settles one edge after its strobe, so the strobe is delayed before capture.
    always_ff @(posedge mclk1) begin
        if (reset) begin
            en_q   <= 1'b0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            en_q   <= din_en;
            s1_vld <= en_q;
            s2_vld <= s1_vld;
        end
    end

    always_ff @(posedge mclk1) begin
        if (en_q) begin
            s1_diff <= $signed({1'b0, din}) - $signed({1'b0, offset});
            s1_gain <= gain;
        end
        if (s1_vld) begin
            s2_prod <= s1_diff * $signed({1'b0, s1_gain});
        end
    end

    always_comb begin
        rnd     = {s2_prod[33], s2_prod} + HALF;
        shifted = rnd >>> GAIN_FRAC;
        res     = shifted[15:0];
        clip    = 1'b0;
        if (shifted > SMAX) begin
            res  = 16'h7FFF;
            clip = 1'b1;
        end else if (shifted < SMIN) begin
            res  = 16'h8000;
            clip = 1'b1;
        end
    end

    assign full    = (level == LW'(DEPTH));
    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign wr_en   = s2_vld && (!full || pop);
    assign drop    = s2_vld && full && !pop;

    assign m_data     = m_valid ? mem[rd_ptr] : 16'h0000;
    assign fifo_level = level;

    always_ff @(posedge mclk1) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= res;
        end
    end

    always_ff @(posedge mclk1) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            sat          <= 1'b0;
            overflow_cnt <= 8'd0;
        end else begin
            sat <= s2_vld && clip;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (clr_ovf) begin
                overflow_cnt <= {7'd0, drop};
            end else if (drop && overflow_cnt != 8'hFF) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sinc3_post_conditioner.sv
// Scoreboard bench for sinc3_post_conditioner: expected words queued at stimulus, checked at FIFO head.
module tb_sinc3_post_conditioner;

    localparam int GF = 14;

    logic        mclk1 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = '0;
    logic        din_en = 1'b0;
    logic [15:0] offset = '0;
    logic [15:0] gain = '0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        sat;
    logic [7:0]  overflow_cnt;
    logic        clr_ovf = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb [$];
    logic [15:0] prev_din = '0, prev_off = '0, prev_gain = '0;

    sinc3_post_conditioner dut (
        .mclk1(mclk1), .reset(reset), .din(din), .din_en(din_en),
        .offset(offset), .gain(gain), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_level(fifo_level), .sat(sat),
        .overflow_cnt(overflow_cnt), .clr_ovf(clr_ovf)
    );

    always #5 mclk1 = ~mclk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] v, input logic [15:0] o, input logic [15:0] g);
        longint d, p, r;
        d = longint'(v) - longint'(o);
        p = d * longint'(g);
        r = (p + (longint'(1) <<< (GF - 1))) >>> GF;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic step();
        @(posedge mclk1);
        #1;
    endtask

    // One clock of filter stimulus: din/offset/gain belong to the strobe of the previous cycle.
    task automatic cycle(input logic en, input logic [15:0] v, input logic [15:0] o,
                         input logic [15:0] g, input logic keep);
        din_en = en;
        din    = prev_din;
        offset = prev_off;
        gain   = prev_gain;
        prev_din  = v;
        prev_off  = o;
        prev_gain = g;
        if (en && keep) sb.push_back(model(v, o, g));
        step();
    endtask

    task automatic pop_chk(input string tag);
        int waited = 0;
        while (!m_valid && waited < 20) begin
            step();
            waited++;
        end
        if (!m_valid) begin
            chk({tag, "_timeout"}, 32'(m_valid), 32'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(m_valid), 32'd0);
        end else begin
            chk(tag, 32'(m_data), 32'(sb.pop_front()));
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
    endtask

    task automatic single(input string tag, input logic [15:0] v, input logic [15:0] o,
                          input logic [15:0] g, input logic [15:0] exp_d, input logic exp_s);
        cycle(1'b1, v, o, g, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
        step();
        chk({tag, "_early_valid"}, 32'(m_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_data"}, 32'(m_data), 32'(exp_d));
        chk({tag, "_sat"}, 32'(sat), 32'(exp_s));
        chk({tag, "_level1"}, 32'(fifo_level), 32'd1);
        pop_chk({tag, "_sb"});
        chk({tag, "_level0"}, 32'(fifo_level), 32'd0);
        step();
        chk({tag, "_sat_gone"}, 32'(sat), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        reset = 1'b0;
        step();

        single("unity", 16'h9000, 16'h8000, 16'h4000, 16'h1000, 1'b0);
        single("sat_pos", 16'h7FFF, 16'h0000, 16'h8000, 16'h7FFF, 1'b1);
        single("sat_neg", 16'h0000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
        single("rnd_p3", 16'd3, 16'd0, 16'h2000, 16'h0002, 1'b0);
        single("rnd_m3", 16'd0, 16'd3, 16'h2000, 16'hFFFF, 1'b0);
        single("rnd_p1", 16'd1, 16'd0, 16'h2000, 16'h0001, 1'b0);

        // Overflow: 11 back-to-back strobes with no consumer.
        for (int i = 1; i <= 11; i++) cycle(1'b1, 16'(i), 16'd0, 16'h4000, i <= 8);
        cycle(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        repeat (3) step();
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_cnt", 32'(overflow_cnt), 32'd3);
        for (int i = 1; i <= 8; i++) pop_chk("ovf_drain");
        chk("ovf_drained", 32'(fifo_level), 32'd0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow_cnt), 32'd0);

        // Full boundary: simultaneous push and pop while full.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i + 100), 16'd0, 16'h4000, 1'b1);
        cycle(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        repeat (3) step();
        chk("full_level", 32'(fifo_level), 32'd8);
        cycle(1'b1, 16'd200, 16'd0, 16'h4000, 1'b1);
        cycle(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        step();
        chk("full_head", 32'(m_data), 32'(sb.pop_front()));
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("full_pp_level", 32'(fifo_level), 32'd8);
        chk("full_pp_ovf", 32'(overflow_cnt), 32'd0);
        cycle(1'b1, 16'd300, 16'd0, 16'h4000, 1'b0);
        cycle(1'b1, 16'd301, 16'd0, 16'h4000, 1'b0);
        cycle(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        repeat (2) step();
        chk("full_ovf2", 32'(overflow_cnt), 32'd2);
        cycle(1'b1, 16'd302, 16'd0, 16'h4000, 1'b0);
        cycle(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_vs_ovf", 32'(overflow_cnt), 32'd1);
        for (int i = 0; i < 8; i++) pop_chk("full_drain");
        chk("full_drained", 32'(fifo_level), 32'd0);

        // Reset with 5 words stored and 2 samples in flight.
        for (int i = 1; i <= 7; i++) cycle(1'b1, 16'(i + 500), 16'd0, 16'h4000, 1'b1);
        cycle(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        chk("mid_level5", 32'(fifo_level), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        chk("mid_valid", 32'(m_valid), 32'd0);
        chk("mid_level", 32'(fifo_level), 32'd0);
        m_ready = 1'b1;
        repeat (4) step();
        m_ready = 1'b0;
        chk("mid_no_stale", 32'(fifo_level), 32'd0);
        chk("mid_ovf", 32'(overflow_cnt), 32'd0);
        single("post_rst", 16'h1234, 16'h0034, 16'h4000, 16'h1200, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
